// File: rtl/cpu_dyn_branch_predictor.sv
// Dynamic branch predictor for the fetch stage.
// Per-index table of 2-bit saturating counters plus a tagged BTB. The table
// is trained from execute-stage resolutions. After every reset, an init
// sequencer clears the table one entry per cycle.
module cpu_dyn_branch_predictor #(
    parameter logic [31:0] p_reset_vector = 32'hf0000000,
    parameter int          p_entries      = 16,
    parameter int          p_tag_width    = 8,
    parameter logic [1:0]  p_init_ctr     = 2'b01
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_en,
    input  logic [31:0] i_pc,
    input  logic        i_cond_br,
    input  logic        i_br_instr,
    input  logic        i_jalr_instr,
    input  logic [31:0] i_imm,
    input  logic        i_upd_valid,
    input  logic [31:0] i_upd_pc,
    input  logic        i_upd_cond,
    input  logic        i_upd_taken,
    input  logic [31:0] i_upd_target,
    output logic [31:0] o_predicted_pc,
    output logic        o_predict_taken,
    output logic        o_branch_instr,
    output logic        o_hit,
    output logic        o_ready
);
    localparam int idx_w  = $clog2(p_entries);
    localparam int tag_lo = idx_w + 2;

    typedef enum logic {ST_INIT, ST_RUN} state_t;

    state_t state, state_nxt;
    logic [idx_w-1:0] ptr;

    logic [1:0]             ctr_q    [p_entries];
    logic [p_tag_width-1:0] tag_q    [p_entries];
    logic [31:0]            target_q [p_entries];
    logic [p_entries-1:0]   valid_q;

    logic run;
    assign run = (state == ST_RUN) && !i_rst;

    // Lookup side: index, tag and hit for the fetched PC.
    logic [idx_w-1:0]       l_idx;
    logic [p_tag_width-1:0] l_tag;
    logic                   l_hit;
    logic [31:0]            pc_plus4, pc_plus_imm;

    assign l_idx       = i_pc[tag_lo-1:2];
    assign l_tag       = i_pc[tag_lo +: p_tag_width];
    assign l_hit       = valid_q[l_idx] && (tag_q[l_idx] == l_tag);
    assign pc_plus4    = i_pc + 32'd4;
    assign pc_plus_imm = i_pc + i_imm;

    // Update side: index, tag and hit for the resolved PC.
    logic [idx_w-1:0]       u_idx;
    logic [p_tag_width-1:0] u_tag;
    logic                   u_hit;

    assign u_idx = i_upd_pc[tag_lo-1:2];
    assign u_tag = i_upd_pc[tag_lo +: p_tag_width];
    assign u_hit = valid_q[u_idx] && (tag_q[u_idx] == u_tag);

    // These PC bits do not take part in indexing or tagging.
    logic unused_pc_bits;
    assign unused_pc_bits = ^{i_pc[31:tag_lo+p_tag_width], i_pc[1:0],
                              i_upd_pc[31:tag_lo+p_tag_width], i_upd_pc[1:0]};

    // State register: reset always restarts the init sequence.
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of block ordering.
    always_ff @(posedge i_clk) begin
        if (i_rst) state <= ST_INIT;
        else       state <= state_nxt;
    end

    // Next state: leave INIT once the last entry has been cleared.
    always_comb begin
        state_nxt = state;
        if (state == ST_INIT && ptr == {idx_w{1'b1}}) state_nxt = ST_RUN;
    end

    // Output decode for the FSM.
    always_comb begin
        o_ready = run;
    end

    // Init pointer: walks the table once per reset.
    always_ff @(posedge i_clk) begin
        if (i_rst)                  ptr <= '0;
        else if (state == ST_INIT) ptr <= ptr + 1'b1;
    end

    // Table writes: init clears entries, RUN applies resolution updates.
    // NOTE: the table arrays have no reset; the init sequencer clears valid
    // and counters, and tags/targets are don't-care while valid is low.
    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            if (state == ST_INIT) begin
                ctr_q[ptr]   <= p_init_ctr;
                valid_q[ptr] <= 1'b0;
            end else if (i_upd_valid) begin
                if (u_hit) begin
                    if (i_upd_cond) begin
                        if (i_upd_taken)
                            ctr_q[u_idx] <= (ctr_q[u_idx] == 2'b11) ? 2'b11 : ctr_q[u_idx] + 2'd1;
                        else
                            ctr_q[u_idx] <= (ctr_q[u_idx] == 2'b00) ? 2'b00 : ctr_q[u_idx] - 2'd1;
                    end else if (i_upd_taken) begin
                        target_q[u_idx] <= i_upd_target;
                    end
                end else if (i_upd_cond || i_upd_taken) begin
                    valid_q[u_idx]  <= 1'b1;
                    tag_q[u_idx]    <= u_tag;
                    target_q[u_idx] <= i_upd_target;
                    ctr_q[u_idx]    <= i_upd_cond ? (i_upd_taken ? 2'b10 : 2'b01) : p_init_ctr;
                end
            end
        end
    end

    // Prediction: zero-latency priority decode over the instruction class.
    // NOTE: every output gets a default first so no path can infer a latch.
    always_comb begin
        o_predicted_pc  = pc_plus4;
        o_predict_taken = 1'b0;
        o_hit           = 1'b0;
        if (i_rst) begin
            o_predicted_pc = p_reset_vector;
        end else if (i_en && run) begin
            o_hit = l_hit;
            if (i_br_instr && !i_cond_br) begin
                o_predicted_pc  = pc_plus_imm;
                o_predict_taken = 1'b1;
            end else if (i_jalr_instr) begin
                o_predicted_pc  = l_hit ? target_q[l_idx] : pc_plus4;
                o_predict_taken = l_hit;
            end else if (i_cond_br) begin
                // A cold branch falls back to backward-taken / forward-not-taken.
                o_predict_taken = l_hit ? ctr_q[l_idx][1] : i_imm[31];
                o_predicted_pc  = o_predict_taken ? pc_plus_imm : pc_plus4;
            end
        end
    end

    assign o_branch_instr = (i_br_instr | i_jalr_instr) & i_en;

endmodule

// File: tb/tb_cpu_dyn_branch_predictor.sv
// Self-checking bench for cpu_dyn_branch_predictor: reset and init timing,
// a directed vector table, hand-written training sequences and randomized
// traffic checked against an abstract reference model.
module tb_cpu_dyn_branch_predictor;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, en, cond_br, br_instr, jalr_instr;
    logic [31:0] pc, imm;
    logic        upd_valid, upd_cond, upd_taken;
    logic [31:0] upd_pc, upd_target;
    logic [31:0] predicted_pc;
    logic        predict_taken, branch_instr, hit, ready;

    int n_cmp  = 0;
    int n_fail = 0;

    cpu_dyn_branch_predictor dut (
        .i_clk(clk), .i_rst(rst), .i_en(en), .i_pc(pc),
        .i_cond_br(cond_br), .i_br_instr(br_instr), .i_jalr_instr(jalr_instr),
        .i_imm(imm), .i_upd_valid(upd_valid), .i_upd_pc(upd_pc),
        .i_upd_cond(upd_cond), .i_upd_taken(upd_taken), .i_upd_target(upd_target),
        .o_predicted_pc(predicted_pc), .o_predict_taken(predict_taken),
        .o_branch_instr(branch_instr), .o_hit(hit), .o_ready(ready)
    );

    // Reference model: table state as plain integers.
    int          m_ctr    [16];
    bit          m_valid  [16];
    int          m_tag    [16];
    logic [31:0] m_target [16];

    typedef struct {
        string       name;
        logic [31:0] pc;
        logic        en, cond, br, jalr;
        logic [31:0] imm;
        logic [31:0] exp_pc;
        logic        exp_taken, exp_hit, exp_bi;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_lookup(input logic [31:0] p, input logic e, c, b, j, input logic [31:0] im);
        pc = p; en = e; cond_br = c; br_instr = b; jalr_instr = j; imm = im;
    endtask

    task automatic do_update(input logic [31:0] p, input logic c, t, input logic [31:0] tgt);
        upd_pc = p; upd_cond = c; upd_taken = t; upd_target = tgt; upd_valid = 1'b1;
        tick();
        upd_valid = 1'b0;
    endtask

    // Counts cycles with ready low after reset release; expects p_entries of them.
    task automatic init_count(input string name);
        int zeros;
        zeros = 0;
        #1;
        for (int i = 0; i < 40 && !ready; i++) begin
            zeros++;
            tick();
        end
        check({name, "_init_cycles"}, zeros, 16);
        check({name, "_ready"}, {31'd0, ready}, 32'd1);
    endtask

    // Checks the current lookup against expected pc / taken / hit.
    task automatic check_lookup(input string name, input logic [31:0] e_pc, input logic e_tk, e_hit);
        #1;
        check({name, "_pc"}, predicted_pc, e_pc);
        check({name, "_taken_hit"}, {30'd0, predict_taken, hit}, {30'd0, e_tk, e_hit});
    endtask

    function automatic void model_clear();
        for (int i = 0; i < 16; i++) begin
            m_ctr[i] = 1; m_valid[i] = 1'b0; m_tag[i] = 0; m_target[i] = '0;
        end
    endfunction

    function automatic void model_lookup(input logic [31:0] p, input logic e, c, b, j,
                                         input logic [31:0] im,
                                         output logic [31:0] e_pc, output logic e_tk, e_hit);
        int  ix, tg;
        bit  h;
        ix = int'((p >> 2) % 16);
        tg = int'((p >> 6) % 256);
        h  = m_valid[ix] && (m_tag[ix] == tg);
        e_pc = p + 4; e_tk = 1'b0; e_hit = 1'b0;
        if (e) begin
            e_hit = h;
            if (b && !c)      begin e_pc = p + im; e_tk = 1'b1; end
            else if (j)       begin e_tk = h; e_pc = h ? m_target[ix] : p + 4; end
            else if (c)       begin
                e_tk = h ? (m_ctr[ix] >= 2) : im[31];
                e_pc = e_tk ? p + im : p + 4;
            end
        end
    endfunction

    function automatic void model_update(input logic [31:0] p, input logic c, t, input logic [31:0] tgt);
        int ix, tg;
        ix = int'((p >> 2) % 16);
        tg = int'((p >> 6) % 256);
        if (m_valid[ix] && m_tag[ix] == tg) begin
            if (c)      m_ctr[ix] = t ? ((m_ctr[ix] < 3) ? m_ctr[ix] + 1 : 3)
                                      : ((m_ctr[ix] > 0) ? m_ctr[ix] - 1 : 0);
            else if (t) m_target[ix] = tgt;
        end else if (c || t) begin
            m_valid[ix] = 1'b1; m_tag[ix] = tg; m_target[ix] = tgt;
            m_ctr[ix] = c ? (t ? 2 : 1) : 1;
        end
    endfunction

    initial begin
        vec_t vecs[8];
        logic [31:0] e_pc;
        logic        e_tk, e_hit;

        rst = 1'b1; upd_valid = 1'b0; upd_pc = '0; upd_cond = 1'b0; upd_taken = 1'b0;
        upd_target = '0;
        set_lookup(32'h100, 1'b1, 1'b1, 1'b1, 1'b0, 32'hfffffff0);

        // Reset held for three cycles: reset vector, nothing taken, not ready.
        for (int i = 0; i < 3; i++) begin
            tick();
            check("rst_pc", predicted_pc, 32'hf0000000);
            check("rst_flags", {29'd0, predict_taken, hit, ready}, 32'd0);
        end
        rst = 1'b0;
        init_count("reset");

        // Directed lookups on a cold table.
        vecs[0] = '{"cond_back",   32'h100,      1, 1, 1, 0, 32'hfffffff0, 32'h0f0,      1, 0, 1};
        vecs[1] = '{"cond_fwd",    32'h100,      1, 1, 1, 0, 32'h10,       32'h104,      0, 0, 1};
        vecs[2] = '{"jal",         32'h300,      1, 0, 1, 0, 32'h40,       32'h340,      1, 0, 1};
        vecs[3] = '{"jalr_miss",   32'h200,      1, 0, 0, 1, 32'h0,        32'h204,      0, 0, 1};
        vecs[4] = '{"plain",       32'h400,      1, 0, 0, 0, 32'h80,       32'h404,      0, 0, 0};
        vecs[5] = '{"jal_wrap",    32'hfffffffc, 1, 0, 1, 0, 32'h8,        32'h00000004, 1, 0, 1};
        vecs[6] = '{"dis_wrap",    32'hfffffffc, 0, 0, 1, 0, 32'h8,        32'h00000000, 0, 0, 0};
        vecs[7] = '{"dis_cond",    32'h100,      0, 1, 1, 0, 32'hfffffff0, 32'h104,      0, 0, 0};
        for (int i = 0; i < 8; i++) begin
            set_lookup(vecs[i].pc, vecs[i].en, vecs[i].cond, vecs[i].br, vecs[i].jalr, vecs[i].imm);
            #1;
            check({vecs[i].name, "_pc"}, predicted_pc, vecs[i].exp_pc);
            check({vecs[i].name, "_flags"}, {29'd0, predict_taken, hit, branch_instr},
                  {29'd0, vecs[i].exp_taken, vecs[i].exp_hit, vecs[i].exp_bi});
            tick();
        end

        // Conditional training at 0x100: lookup is forward so only the counter can say taken.
        set_lookup(32'h100, 1'b1, 1'b1, 1'b1, 1'b0, 32'h10);
        upd_pc = 32'h100; upd_cond = 1'b1; upd_taken = 1'b1; upd_target = 32'h110; upd_valid = 1'b1;
        check_lookup("same_cycle_pre", 32'h104, 1'b0, 1'b0);
        tick();
        upd_valid = 1'b0;
        check_lookup("ctr_10", 32'h110, 1'b1, 1'b1);
        do_update(32'h100, 1'b1, 1'b1, 32'h110);
        check_lookup("ctr_11", 32'h110, 1'b1, 1'b1);
        do_update(32'h100, 1'b1, 1'b1, 32'h110);
        check_lookup("ctr_11_sat", 32'h110, 1'b1, 1'b1);
        do_update(32'h100, 1'b1, 1'b0, 32'h110);
        check_lookup("ctr_10_dec", 32'h110, 1'b1, 1'b1);
        do_update(32'h100, 1'b1, 1'b0, 32'h110);
        check_lookup("ctr_01", 32'h104, 1'b0, 1'b1);

        // JALR at 0x200: not-taken never allocates, taken installs the target.
        set_lookup(32'h200, 1'b1, 1'b0, 1'b0, 1'b1, 32'h0);
        do_update(32'h200, 1'b0, 1'b0, 32'h4000);
        check_lookup("jalr_nt_noalloc", 32'h204, 1'b0, 1'b0);
        do_update(32'h200, 1'b0, 1'b1, 32'h8000);
        check_lookup("jalr_hit", 32'h8000, 1'b1, 1'b1);

        // Reset pulse mid-RUN: init reruns and trained entries are gone.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        init_count("rerun");
        set_lookup(32'h100, 1'b1, 1'b1, 1'b1, 1'b0, 32'h10);
        check_lookup("rerun_cond_miss", 32'h104, 1'b0, 1'b0);
        set_lookup(32'h200, 1'b1, 1'b0, 1'b0, 1'b1, 32'h0);
        check_lookup("rerun_jalr_miss", 32'h204, 1'b0, 1'b0);

        // Randomized traffic on a small PC pool so entries hit, alias and get replaced.
        model_clear();
        for (int n = 0; n < 600; n++) begin
            int          k, r;
            logic [31:0] p, up;
            p  = (32'($urandom_range(0, 3)) << 6) | (32'($urandom_range(0, 15)) << 2);
            if ($urandom_range(0, 7) == 0) p = p | ($urandom & 32'hffffc000);
            up = (32'($urandom_range(0, 3)) << 6) | (32'($urandom_range(0, 15)) << 2);
            k  = int'($urandom_range(0, 3));
            r  = int'($urandom_range(0, 511));
            set_lookup(p, $urandom_range(0, 9) != 0, k == 0, k <= 1, k == 2, 32'((r - 256) * 4));
            upd_pc = up; upd_cond = 1'($urandom); upd_taken = 1'($urandom);
            upd_target = $urandom & 32'hfffffffc; upd_valid = 1'($urandom);
            model_lookup(pc, en, cond_br, br_instr, jalr_instr, imm, e_pc, e_tk, e_hit);
            check_lookup("rand", e_pc, e_tk, e_hit);
            tick();
            if (upd_valid) model_update(upd_pc, upd_cond, upd_taken, upd_target);
        end
        upd_valid = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
